cpu_mem_bridge: RTL and testbench

Bridges the multicycle core's single-beat memory port to the SoC bus with a registered valid/ready handshake. It sits directly downstream of the datapath's address/write-data/strobe outputs and upstream of its read-data input. The control unit issues one request at a time and waits for a one-cycle response pulse. An optional timeout converts a hung bus into an access-fault indication.

---
 rtl/cpu_mem_bridge_pkg.sv | 24 ++
 rtl/cpu_mem_bridge_bus_timeout_counter.sv | 37 +++
 rtl/cpu_mem_bridge.sv | 145 ++++++++++++++
 tb/tb_cpu_mem_bridge.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_bridge_pkg.sv
// cpu_mem_bridge_pkg: shared constants and types for the core-to-bus memory bridge.
//   - Bridge FSM state encoding (2 bits) and its width.
//   - Default bus-wait timeout in cycles.
//   - Write-strobe encoding that denotes a read.
//   - Helper that word-aligns a byte address.
package cpu_mem_bridge_pkg;

  localparam int unsigned BRIDGE_STATE_WIDTH = 2;

  typedef enum logic [BRIDGE_STATE_WIDTH-1:0] {
    BRIDGE_IDLE = 2'd0,
    BRIDGE_BUS  = 2'd1,
    BRIDGE_RESP = 2'd2
  } bridge_state_e;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1024;

  localparam logic [3:0] WSTRB_READ = 4'b0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/cpu_mem_bridge_bus_timeout_counter.sv
// cpu_mem_bridge_bus_timeout_counter: 16-bit bus-wait counter for the bridge.
// Counts cycles while enabled and flags terminal count at TIMEOUT_CYCLES-1.
// Ports:
//   i_clk, i_resetn : clock, asynchronous active-low reset
//   i_clear         : synchronous clear (has priority over i_enable)
//   i_enable        : increment this cycle
//   o_terminal      : count has reached TIMEOUT_CYCLES-1
// Only instantiated when KIANV_BUS_TIMEOUT_EN is defined.
module cpu_mem_bridge_bus_timeout_counter
  import cpu_mem_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic i_clk,
  input  logic i_resetn,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_terminal
);

  localparam logic [15:0] TERMINAL = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_count;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign o_terminal = (r_count == TERMINAL);

endmodule

// File: rtl/cpu_mem_bridge.sv
// cpu_mem_bridge: single-beat memory port of the multicycle core to the SoC
// valid/ready bus. One outstanding request; response is a one-cycle pulse.
// Ports:
//   i_clk, i_resetn                  : clock, asynchronous active-low reset
//   i_req_valid/o_req_ready          : request handshake from the control unit
//   i_req_addr/i_req_wdata/i_req_wstrb : request payload (wstrb 0 = read)
//   o_rsp_valid/o_rsp_rdata/o_rsp_error : response pulse, held read data, timeout flag
//   o_busy                           : request outstanding
//   o_bus_valid/i_bus_ready          : bus handshake
//   o_bus_addr/o_bus_wdata/o_bus_wstrb : captured, word-aligned bus payload
//   i_bus_rdata                      : bus read data, valid with i_bus_ready
// Build option: define KIANV_BUS_TIMEOUT_EN to abort a bus wait after
// TIMEOUT_CYCLES cycles with o_rsp_error=1; otherwise the bridge waits forever.
module cpu_mem_bridge
  import cpu_mem_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        i_clk,
  input  logic        i_resetn,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_wstrb,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_error,
  output logic        o_busy,
  output logic        o_bus_valid,
  input  logic        i_bus_ready,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  output logic [3:0]  o_bus_wstrb,
  input  logic [31:0] i_bus_rdata
);

  bridge_state_e r_state, w_state_next;

  logic [31:0] r_bus_addr, w_bus_addr_next;
  logic [31:0] r_bus_wdata, w_bus_wdata_next;
  logic [3:0]  r_bus_wstrb, w_bus_wstrb_next;
  logic [31:0] r_rsp_rdata, w_rsp_rdata_next;
  logic        r_rsp_error, w_rsp_error_next;
  logic        r_rsp_valid, r_bus_valid, r_req_ready, r_busy;
  logic        w_timeout;
  logic [1:0]  w_unused_addr_lsb;

  // Byte offset is dropped: the bus is word addressed, lanes come from wstrb.
  assign w_unused_addr_lsb = i_req_addr[1:0];

`ifdef KIANV_BUS_TIMEOUT_EN
  logic w_cnt_clear, w_cnt_enable;

  // Held clear outside BUS so every bus wait starts counting from zero.
  assign w_cnt_clear  = (r_state != BRIDGE_BUS);
  assign w_cnt_enable = (r_state == BRIDGE_BUS) && !i_bus_ready;

  cpu_mem_bridge_bus_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_resetn  (i_resetn),
    .i_clear   (w_cnt_clear),
    .i_enable  (w_cnt_enable),
    .o_terminal(w_timeout)
  );
`else
  logic [31:0] w_unused_timeout_cycles;
  assign w_unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_next     = r_state;
    w_bus_addr_next  = r_bus_addr;
    w_bus_wdata_next = r_bus_wdata;
    w_bus_wstrb_next = r_bus_wstrb;
    w_rsp_rdata_next = r_rsp_rdata;
    w_rsp_error_next = r_rsp_error;
    unique case (r_state)
      BRIDGE_IDLE: begin
        if (i_req_valid) begin
          w_state_next     = BRIDGE_BUS;
          w_bus_addr_next  = word_align(i_req_addr);
          w_bus_wdata_next = i_req_wdata;
          w_bus_wstrb_next = i_req_wstrb;
        end
      end
      BRIDGE_BUS: begin
        // bus_ready takes priority over a coincident terminal count.
        if (i_bus_ready) begin
          w_state_next     = BRIDGE_RESP;
          w_rsp_rdata_next = i_bus_rdata;
          w_rsp_error_next = 1'b0;
        end else if (w_timeout) begin
          w_state_next     = BRIDGE_RESP;
          w_rsp_rdata_next = '0;
          w_rsp_error_next = 1'b1;
        end
      end
      BRIDGE_RESP: w_state_next = BRIDGE_IDLE;
      default:     w_state_next = BRIDGE_IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so they are glitch-free
  // and have no combinational path from the bus inputs.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state     <= BRIDGE_IDLE;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_wstrb <= '0;
      r_rsp_rdata <= '0;
      r_rsp_error <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_bus_valid <= 1'b0;
      r_req_ready <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_bus_addr  <= w_bus_addr_next;
      r_bus_wdata <= w_bus_wdata_next;
      r_bus_wstrb <= w_bus_wstrb_next;
      r_rsp_rdata <= w_rsp_rdata_next;
      r_rsp_error <= w_rsp_error_next;
      r_rsp_valid <= (w_state_next == BRIDGE_RESP);
      r_bus_valid <= (w_state_next == BRIDGE_BUS);
      r_req_ready <= (w_state_next == BRIDGE_IDLE);
      r_busy      <= (w_state_next != BRIDGE_IDLE);
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_busy      = r_busy;
  assign o_bus_valid = r_bus_valid;
  assign o_bus_addr  = r_bus_addr;
  assign o_bus_wdata = r_bus_wdata;
  assign o_bus_wstrb = r_bus_wstrb;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_error = r_rsp_error;

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// tb_cpu_mem_bridge: self-checking bench for cpu_mem_bridge.
// Table of accesses plus hand-written sequences for busy rejection, stray
// bus_ready, timeout (when KIANV_BUS_TIMEOUT_EN is defined) and reset mid-access.
module tb_cpu_mem_bridge;

  localparam int unsigned TO_CYCLES = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        busy;
  logic        bus_valid;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_rdata = '0;

  always #5 clk = ~clk;

  cpu_mem_bridge #(
    .TIMEOUT_CYCLES(TO_CYCLES)
  ) dut (
    .i_clk      (clk),
    .i_resetn   (resetn),
    .i_req_valid(req_valid),
    .o_req_ready(req_ready),
    .i_req_addr (req_addr),
    .i_req_wdata(req_wdata),
    .i_req_wstrb(req_wstrb),
    .o_rsp_valid(rsp_valid),
    .o_rsp_rdata(rsp_rdata),
    .o_rsp_error(rsp_error),
    .o_busy     (busy),
    .o_bus_valid(bus_valid),
    .i_bus_ready(bus_ready),
    .o_bus_addr (bus_addr),
    .o_bus_wdata(bus_wdata),
    .o_bus_wstrb(bus_wstrb),
    .i_bus_rdata(bus_rdata)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int unsigned wait_n;
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        error;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t mon_e;
  int   n_total = 0;
  int   n_pass = 0;
  int   n_rsp = 0;
  int   n_exp_rsp = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check32(name, {31'b0, act}, {31'b0, exp});
  endtask

  // Scoreboard: every rsp_valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rsp_valid) begin
      n_rsp++;
      if (exp_q.size() == 0) begin
        check1("unexpected rsp_valid", rsp_valid, 1'b0);
      end else begin
        mon_e = exp_q.pop_front();
        check32("rsp_rdata", rsp_rdata, mon_e.rdata);
        check1("rsp_error", rsp_error, mon_e.error);
      end
    end
  end

  task automatic expect_rsp(input logic [31:0] rdata, input logic error);
    rsp_t e;
    e.rdata = rdata;
    e.error = error;
    exp_q.push_back(e);
    n_exp_rsp++;
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the first BUS cycle.
  task automatic issue(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
    check1("req_ready before issue", req_ready, 1'b1);
    req_valid = 1'b1;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = wstrb;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom();
    req_wdata = $urandom();
  endtask

  // Runs n_cyc BUS cycles; bus_ready asserted on the last one if give_ready.
  // Returns at the negedge of the following IDLE cycle.
  task automatic bus_phase(input logic [31:0] exp_addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input int unsigned n_cyc,
                           input bit give_ready, input logic [31:0] rdata,
                           input logic [31:0] exp_hold, input bit hold,
                           input logic [31:0] hold_addr);
    for (int c = 0; c < int'(n_cyc); c++) begin
      check1("bus_valid in BUS", bus_valid, 1'b1);
      check32("bus_addr", bus_addr, exp_addr);
      check32("bus_wdata", bus_wdata, wdata);
      check32("bus_wstrb", {28'b0, bus_wstrb}, {28'b0, wstrb});
      check1("req_ready in BUS", req_ready, 1'b0);
      check1("busy in BUS", busy, 1'b1);
      if (hold) begin
        req_valid = 1'b1;
        req_addr  = hold_addr;
        req_wdata = ~wdata;
        req_wstrb = ~wstrb;
      end
      bus_ready = give_ready && (c == int'(n_cyc) - 1);
      bus_rdata = bus_ready ? rdata : $urandom();
      @(negedge clk);
    end
    bus_ready = 1'b0;
    bus_rdata = $urandom();
    check1("bus_valid in RESP", bus_valid, 1'b0);
    check1("req_ready in RESP", req_ready, 1'b0);
    check1("rsp_valid in RESP", rsp_valid, 1'b1);
    @(negedge clk);
    check1("req_ready back in IDLE", req_ready, 1'b1);
    check1("busy back in IDLE", busy, 1'b0);
    check1("rsp_valid single pulse", rsp_valid, 1'b0);
    check32("rsp_rdata held", rsp_rdata, exp_hold);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[5];
    logic [31:0] a2;
    vecs[0] = '{32'h8000_0006, 32'h0000_0000, 4'b0000, 0, 32'hDEAD_BEEF};
    vecs[1] = '{32'h0000_0100, 32'h0000_1234, 4'b0011, 4, 32'h0BAD_F00D};
    vecs[2] = '{32'h1234_5673, 32'hA5A5_5A5A, 4'b1111, 1, 32'h1111_2222};
    vecs[3] = '{32'hFFFF_FFFF, 32'h0000_0000, 4'b0000, 2, 32'hCAFE_0001};
    vecs[4] = '{32'h0000_0008, 32'hFF00_0000, 4'b1000, 0, 32'h0000_0000};

    // Reset state
    repeat (3) @(negedge clk);
    check1("reset req_ready", req_ready, 1'b1);
    check1("reset busy", busy, 1'b0);
    check1("reset bus_valid", bus_valid, 1'b0);
    check1("reset rsp_valid", rsp_valid, 1'b0);
    check1("reset rsp_error", rsp_error, 1'b0);
    check32("reset rsp_rdata", rsp_rdata, 32'h0);
    check32("reset bus_addr", bus_addr, 32'h0);
    check32("reset bus_wdata", bus_wdata, 32'h0);
    check32("reset bus_wstrb", {28'b0, bus_wstrb}, 32'h0);
    resetn = 1'b1;
    @(negedge clk);
    check1("req_ready after release", req_ready, 1'b1);

    // Table of accesses with varying wait states
    for (int i = 0; i < 5; i++) begin
      issue(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb);
      expect_rsp(vecs[i].rdata, 1'b0);
      bus_phase(vecs[i].addr & 32'hFFFF_FFFC, vecs[i].wdata, vecs[i].wstrb, vecs[i].wait_n + 1,
                1'b1, vecs[i].rdata, vecs[i].rdata, 1'b0, 32'h0);
    end

    // bus_ready outside BUS must be ignored
    bus_ready = 1'b1;
    bus_rdata = 32'h5555_AAAA;
    repeat (2) @(negedge clk);
    check1("stray bus_ready: bus_valid", bus_valid, 1'b0);
    check1("stray bus_ready: req_ready", req_ready, 1'b1);
    check32("stray bus_ready: rsp_rdata", rsp_rdata, vecs[4].rdata);
    bus_ready = 1'b0;

    // Held req_valid with a new address during BUS: no recapture; taken in IDLE
    issue(32'h1000_0010, 32'h0F0F_0F0F, 4'b1111);
    expect_rsp(32'h7777_0000, 1'b0);
    bus_phase(32'h1000_0010, 32'h0F0F_0F0F, 4'b1111, 3, 1'b1, 32'h7777_0000, 32'h7777_0000,
              1'b1, 32'h2000_0021);
    // req_valid is still high here, so the next edge accepts the held request
    expect_rsp(32'h7777_1111, 1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    a2 = 32'h2000_0020;
    bus_phase(a2, 32'hF0F0_F0F0, 4'b0000, 1, 1'b1, 32'h7777_1111, 32'h7777_1111, 1'b0, 32'h0);

`ifdef KIANV_BUS_TIMEOUT_EN
    // Timeout: bus_valid high exactly TO_CYCLES cycles, then error response
    issue(32'h4000_0004, 32'h0, 4'b0000);
    expect_rsp(32'h0, 1'b1);
    bus_phase(32'h4000_0004, 32'h0, 4'b0000, TO_CYCLES, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    // bus_ready on the terminal cycle wins over the timeout
    issue(32'h4000_0008, 32'h0, 4'b0000);
    expect_rsp(32'h600D_600D, 1'b0);
    bus_phase(32'h4000_0008, 32'h0, 4'b0000, TO_CYCLES, 1'b1, 32'h600D_600D, 32'h600D_600D,
              1'b0, 32'h0);
`endif

    // Reset mid-access: bus_valid drops asynchronously, no response afterwards
    issue(32'h3000_0000, 32'hABCD_0123, 4'b0101);
    check1("pre-reset bus_valid", bus_valid, 1'b1);
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check1("async reset bus_valid", bus_valid, 1'b0);
    check1("async reset busy", busy, 1'b0);
    check1("async reset req_ready", req_ready, 1'b1);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check1("no rsp after reset", rsp_valid, 1'b0);
    end
    check1("req_ready after mid reset", req_ready, 1'b1);
    check32("rsp_rdata after mid reset", rsp_rdata, 32'h0);

    check32("response count", n_rsp, n_exp_rsp);
    check32("pending expectations", exp_q.size(), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
